// File: rtl/dispatch_gate_pkg.sv
// Shared core configuration for the dispatch gate: packet width, queue
// sizes, bundle bookkeeping types and a small popcount helper.
package dispatch_gate_pkg;

    localparam int CORE_PKT_W    = 160;
    localparam int CORE_IQ_SIZE  = 32;
    localparam int CORE_ROB_SIZE = 128;
    localparam int CORE_LSQ_SIZE = 32;
    localparam int SLOTS         = 4;

    // Entry counts per cycle are 0..4, so three bits are enough.
    typedef logic [2:0] count_t;

    // Control half of the held bundle; the packets live alongside it.
    typedef struct packed {
        logic             occupied;
        logic [SLOTS-1:0] valid;
        logic [SLOTS-1:0] ldst;
    } bundleCtl_t;

    function automatic count_t popcount4(input logic [SLOTS-1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/dispatch_gate_if.sv
// Upstream bundle handshake between the rename/dispatch pipeline register
// and the dispatch gate. The gate answers with a hold request.
interface dispatch_gate_if
    import dispatch_gate_pkg::*;
#(
    parameter int PKT_W = CORE_PKT_W
) ();

    logic             renameReady;
    logic [PKT_W-1:0] renamedPacket0;
    logic [PKT_W-1:0] renamedPacket1;
    logic [PKT_W-1:0] renamedPacket2;
    logic [PKT_W-1:0] renamedPacket3;
    logic [3:0]       instValid;
    logic [3:0]       isLdSt;
    logic             stall;

    modport master (
        output renameReady, renamedPacket0, renamedPacket1, renamedPacket2,
               renamedPacket3, instValid, isLdSt,
        input  stall
    );

    modport slave (
        input  renameReady, renamedPacket0, renamedPacket1, renamedPacket2,
               renamedPacket3, instValid, isLdSt,
        output stall
    );

endinterface

// File: rtl/dispatch_credit_counter.sv
// Free-entry credit for one backend queue. Entries consumed by a dispatch
// leave the pool at the same edge that freed entries return to it, so a
// freed entry is only spendable from the following cycle. Returning more
// than the queue can hold clamps at SIZE and latches a sticky error.
module dispatch_credit_counter
    import dispatch_gate_pkg::*;
#(
    parameter  int SIZE = 32,
    localparam int CW   = $clog2(SIZE) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  count_t        use_i,
    input  count_t        freed_i,
    output logic [CW-1:0] credit_o,
    output logic          overflow_o
);

    localparam int SW = CW + 1;

    logic [CW-1:0] credit_q, credit_d;
    logic          overflow_q, overflow_d;
    logic [SW-1:0] sum;

    // Next credit: subtract this cycle's dispatch, add this cycle's frees, clamp.
    always_comb begin
        sum        = {1'b0, credit_q} - SW'(use_i) + SW'(freed_i);
        credit_d   = sum[CW-1:0];
        overflow_d = overflow_q;
        if (sum > SW'(SIZE)) begin
            credit_d   = CW'(SIZE);
            overflow_d = 1'b1;
        end
    end

    // Credit and sticky overflow registers; reset refills the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q   <= CW'(SIZE);
            overflow_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    assign credit_o   = credit_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/dispatch_gate.sv
// Dispatch gate: holds one renamed bundle and releases it to the backend
// only when every slot fits in the issue queue, ROB and LSQ at once.
module dispatch_gate
    import dispatch_gate_pkg::*;
#(
    parameter int PKT_W    = CORE_PKT_W,
    parameter int IQ_SIZE  = CORE_IQ_SIZE,
    parameter int ROB_SIZE = CORE_ROB_SIZE,
    parameter int LSQ_SIZE = CORE_LSQ_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             backendStall_i,
    dispatch_gate_if.slave   bundle,
    input  count_t           iqFreed_i,
    input  count_t           robFreed_i,
    input  count_t           lsqFreed_i,
    output logic             stall_o,
    output logic [PKT_W-1:0] dispatchedPacket0_o,
    output logic [PKT_W-1:0] dispatchedPacket1_o,
    output logic [PKT_W-1:0] dispatchedPacket2_o,
    output logic [PKT_W-1:0] dispatchedPacket3_o,
    output logic [3:0]       dispatchValid_o,
    output logic             creditError_o
);

    localparam int IQ_CW  = $clog2(IQ_SIZE) + 1;
    localparam int ROB_CW = $clog2(ROB_SIZE) + 1;
    localparam int LSQ_CW = $clog2(LSQ_SIZE) + 1;

    bundleCtl_t                   hCtl_q, hCtl_d;
    logic [SLOTS-1:0][PKT_W-1:0]  hPkt_q, hPkt_d;
    logic [SLOTS-1:0][PKT_W-1:0]  dispPkt_q, dispPkt_d;
    logic [3:0]                   dispValid_q, dispValid_d;

    count_t              needIq, needLsq;
    count_t              useIq, useRob, useLsq;
    logic [IQ_CW-1:0]    iqCredit;
    logic [ROB_CW-1:0]   robCredit;
    logic [LSQ_CW-1:0]   lsqCredit;
    logic                iqOverflow, robOverflow, lsqOverflow;
    logic                fire, loadEn;

    // Decide whether the held bundle leaves this cycle; the whole bundle goes or nothing does.
    always_comb begin
        needIq  = popcount4(hCtl_q.valid);
        needLsq = popcount4(hCtl_q.valid & hCtl_q.ldst);
        fire    = hCtl_q.occupied && !backendStall_i && !flush_i
                  && (iqCredit  >= IQ_CW'(needIq))
                  && (robCredit >= ROB_CW'(needIq))
                  && (lsqCredit >= LSQ_CW'(needLsq));
        stall_o = hCtl_q.occupied && !fire && !flush_i;
        loadEn  = bundle.renameReady && !stall_o && !flush_i;
        useIq   = fire ? needIq  : 3'd0;
        useRob  = fire ? needIq  : 3'd0;
        useLsq  = fire ? needLsq : 3'd0;
    end

    // Next contents of the holding register: flush empties it, a new bundle replaces it, a dispatch frees it.
    always_comb begin
        hCtl_d = hCtl_q;
        hPkt_d = hPkt_q;
        if (flush_i) begin
            hCtl_d.occupied = 1'b0;
        end else if (loadEn) begin
            hCtl_d.occupied = |bundle.instValid;
            hCtl_d.valid    = bundle.instValid;
            hCtl_d.ldst     = bundle.isLdSt;
            hPkt_d[0]       = bundle.renamedPacket0;
            hPkt_d[1]       = bundle.renamedPacket1;
            hPkt_d[2]       = bundle.renamedPacket2;
            hPkt_d[3]       = bundle.renamedPacket3;
        end else if (fire) begin
            hCtl_d.occupied = 1'b0;
        end
    end

    // Dispatched bundle: valid only for the cycle after a fire, packets keep their last value.
    always_comb begin
        dispValid_d = fire ? hCtl_q.valid : 4'b0000;
        dispPkt_d   = fire ? hPkt_q : dispPkt_q;
    end

    // Holding register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hCtl_q <= '0;
            hPkt_q <= '0;
        end else begin
            hCtl_q <= hCtl_d;
            hPkt_q <= hPkt_d;
        end
    end

    // Registered dispatch outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dispValid_q <= 4'b0000;
            dispPkt_q   <= '0;
        end else begin
            dispValid_q <= dispValid_d;
            dispPkt_q   <= dispPkt_d;
        end
    end

    dispatch_credit_counter #(.SIZE(IQ_SIZE)) u_iqCredit (
        .clk        (clk),
        .reset      (reset),
        .use_i      (useIq),
        .freed_i    (iqFreed_i),
        .credit_o   (iqCredit),
        .overflow_o (iqOverflow)
    );

    dispatch_credit_counter #(.SIZE(ROB_SIZE)) u_robCredit (
        .clk        (clk),
        .reset      (reset),
        .use_i      (useRob),
        .freed_i    (robFreed_i),
        .credit_o   (robCredit),
        .overflow_o (robOverflow)
    );

    dispatch_credit_counter #(.SIZE(LSQ_SIZE)) u_lsqCredit (
        .clk        (clk),
        .reset      (reset),
        .use_i      (useLsq),
        .freed_i    (lsqFreed_i),
        .credit_o   (lsqCredit),
        .overflow_o (lsqOverflow)
    );

    assign bundle.stall        = stall_o;
    assign dispatchValid_o     = dispValid_q;
    assign dispatchedPacket0_o = dispPkt_q[0];
    assign dispatchedPacket1_o = dispPkt_q[1];
    assign dispatchedPacket2_o = dispPkt_q[2];
    assign dispatchedPacket3_o = dispPkt_q[3];
    assign creditError_o       = iqOverflow | robOverflow | lsqOverflow;

endmodule
